// File: rtl/vga_buffer_reader.sv
// Read-port sequencer for the frame buffer: produces VGA timing, fetches the image
// placed at the top-left corner and aligns the returned pixels with the sync outputs.
module vga_buffer_reader #(
   parameter int AW     = 15,
   parameter int DW     = 8,
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 120,
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_ce,
   output logic [AW-1:0] addr_out,
   output logic          regread,
   input  logic [DW-1:0] data_in,
   output logic          vga_hsync,
   output logic          vga_vsync,
   output logic [DW-1:0] vga_data,
   output logic          display_en,
   output logic          frame_start
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);

   localparam logic [HW-1:0] L_H_LAST   = HW'(H_TOT - 1);
   localparam logic [HW-1:0] L_IMG_W    = HW'(IMG_W);
   localparam logic [HW-1:0] L_H_VIS    = HW'(H_VIS);
   localparam logic [HW-1:0] L_HS_BEG   = HW'(H_VIS + H_FP);
   localparam logic [HW-1:0] L_HS_END   = HW'(H_VIS + H_FP + H_SYNC);
   localparam logic [VW-1:0] L_V_LAST   = VW'(V_TOT - 1);
   localparam logic [VW-1:0] L_IMG_H    = VW'(IMG_H);
   localparam logic [VW-1:0] L_V_VIS    = VW'(V_VIS);
   localparam logic [VW-1:0] L_VS_BEG   = VW'(V_VIS + V_FP);
   localparam logic [VW-1:0] L_VS_END   = VW'(V_VIS + V_FP + V_SYNC);

   logic [HW-1:0] r_h_cnt;
   logic [VW-1:0] r_v_cnt;
   logic [AW-1:0] r_addr_cnt;

   logic r_hs_s1, r_vs_s1, r_vis_s1, r_img_s1, r_first_s1;
   logic r_hsync, r_vsync, r_disp_en, r_frame_start;
   logic [DW-1:0] r_data;

   logic w_h_last, w_v_last, w_frame_end;
   logic w_in_img, w_vis, w_hs, w_vs, w_first;

   assign w_h_last    = (r_h_cnt == L_H_LAST);
   assign w_v_last    = (r_v_cnt == L_V_LAST);
   assign w_frame_end = w_h_last && w_v_last;

   assign w_in_img = (r_h_cnt < L_IMG_W) && (r_v_cnt < L_IMG_H);
   assign w_vis    = (r_h_cnt < L_H_VIS) && (r_v_cnt < L_V_VIS);
   assign w_hs     = !((r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END));
   assign w_vs     = !((r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END));
   assign w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);

   assign regread  = w_in_img && pix_ce && !rst;
   assign addr_out = r_addr_cnt;

   // The address walks the image row-major without a multiplier: it only
   // advances inside the image and holds across the rest of each line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h_cnt    <= '0;
         r_v_cnt    <= '0;
         r_addr_cnt <= '0;
      end else if (pix_ce) begin
         if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
         end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
         end
         if (w_frame_end)
            r_addr_cnt <= '0;
         else if (w_in_img)
            r_addr_cnt <= r_addr_cnt + AW'(1);
      end
   end

   // Syncs are held inactive in the cleared pipeline so no pulse leaks out after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs_s1    <= 1'b1;
         r_vs_s1    <= 1'b1;
         r_vis_s1   <= 1'b0;
         r_img_s1   <= 1'b0;
         r_first_s1 <= 1'b0;
      end else if (pix_ce) begin
         r_hs_s1    <= w_hs;
         r_vs_s1    <= w_vs;
         r_vis_s1   <= w_vis;
         r_img_s1   <= w_in_img;
         r_first_s1 <= w_first;
      end
   end

   // data_in is the buffer's registered read issued one ce tick earlier; it holds
   // across ce-low cycles because no new read is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_disp_en     <= 1'b0;
         r_frame_start <= 1'b0;
         r_data        <= '0;
      end else if (pix_ce) begin
         r_hsync       <= r_hs_s1;
         r_vsync       <= r_vs_s1;
         r_disp_en     <= r_vis_s1;
         r_frame_start <= r_first_s1;
         r_data        <= r_img_s1 ? data_in : '0;
      end
   end

   assign vga_hsync   = r_hsync;
   assign vga_vsync   = r_vsync;
   assign display_en  = r_disp_en;
   assign frame_start = r_frame_start;
   assign vga_data    = r_data;

endmodule

// File: tb/tb_vga_buffer_reader.sv
// Randomized bench for vga_buffer_reader on a reduced timing raster; a pixel-index
// reference model fills an expected queue that a monitor drains on every ce edge.
module tb_vga_buffer_reader;

  localparam int AW = 8, DW = 8;
  localparam int IMG_W = 20, IMG_H = 12;
  localparam int H_VIS = 40, H_FP = 4, H_SYNC = 8, H_BP = 6;
  localparam int V_VIS = 30, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int EW    = DW + 4;
  localparam logic [EW-1:0] IDLE = {1'b1, 1'b1, 1'b0, 1'b0, {DW{1'b0}}};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_ce = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] addr_out;
  logic          regread;
  logic [DW-1:0] data_in = '0;
  logic          vga_hsync, vga_vsync, display_en, frame_start;
  logic [DW-1:0] vga_data;

  vga_buffer_reader #(
    .AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .addr_out(addr_out), .regread(regread), .data_in(data_in),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_data(vga_data),
    .display_en(display_en), .frame_start(frame_start)
  );

  // frame buffer read port model: registered read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (regread) data_in <= mem[addr_out];

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // reference model: expected pins for pixel index p since reset release
  function automatic logic [EW-1:0] model(input int p);
    int h, v;
    logic img, vis, hs, vs, fs;
    logic [DW-1:0] d;
    h   = p % H_TOT;
    v   = (p / H_TOT) % V_TOT;
    img = (h < IMG_W) && (v < IMG_H);
    vis = (h < H_VIS) && (v < V_VIS);
    hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
    vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
    fs  = (h == 0) && (v == 0);
    d   = img ? mem[v * IMG_W + h] : '0;
    return {hs, vs, vis, fs, d};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, 32'(vga_hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vga_vsync), 32'd1);
    chk({tag, "_data"}, 32'(vga_data), 32'd0);
    chk({tag, "_en"}, 32'(display_en), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_regread"}, 32'(regread), 32'd0);
  endtask

  // driver tasks
  task automatic apply_reset(input int n_clk);
    rst = 1'b1;
    pix_ce = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    repeat (n_clk) begin
      @(negedge clk);
      chk_reset_outputs("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    pix_ce = 1'b0;
    exp_q.delete();
    exp_q.push_back(IDLE);
    t = 0;
  endtask

  task automatic tick(input logic ce);
    int h, v;
    logic img;
    @(negedge clk);
    pix_ce = ce;
    #1;
    if (ce) begin
      h   = t % H_TOT;
      v   = (t / H_TOT) % V_TOT;
      img = (h < IMG_W) && (v < IMG_H);
      chk("regread", 32'(regread), 32'(img));
      if (img) chk("addr_out", 32'(addr_out), 32'(v * IMG_W + h));
      exp_q.push_back(model(t));
      t++;
    end else begin
      chk("regread_ce0", 32'(regread), 32'd0);
    end
  endtask

  // monitor: one output pixel per active ce edge
  always @(posedge clk) begin
    if (!rst && pix_ce) begin
      logic [EW-1:0] e;
      #1;
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("vga_hsync", 32'(vga_hsync), 32'(e[DW+3]));
        chk("vga_vsync", 32'(vga_vsync), 32'(e[DW+2]));
        chk("display_en", 32'(display_en), 32'(e[DW+1]));
        chk("frame_start", 32'(frame_start), 32'(e[DW]));
        chk("vga_data", 32'(vga_data), 32'(e[DW-1:0]));
      end
    end
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    #2;
    apply_reset(3);

    // two full frames plus a little at full pixel rate
    repeat (2 * FRAME + 100) tick(1'b1);

    // pixel clock at half rate
    repeat (FRAME) begin
      tick(1'b1);
      tick(1'b0);
    end

    // irregular ce pattern
    repeat (600) tick(1'(($urandom_range(0, 3) != 0)));

    // mid-frame asynchronous reset at (30,5)
    while ((t % FRAME) != (5 * H_TOT + 30)) tick(1'b1);
    @(posedge clk);
    #3;
    apply_reset(3);
    repeat (300) tick(1'b1);
    repeat (4) tick(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_buffer_reader.md
Name: vga_buffer_reader

Overview:
Read-port sequencer for the dual-port frame buffer. It generates 640x480@60 VGA timing and issues read address and read enable to the buffer. The stored image (IMG_W x IMG_H, row-major) is placed at the top-left of the screen, and the returned pixel data is aligned with the sync signals. Black is driven outside the image and during blanking. The block sits between the frame buffer read port and the VGA pins.

Parameters:
AW, 15, buffer address width (must satisfy 2**AW >= IMG_W*IMG_H)
DW, 8, pixel width (RGB332)
IMG_W, 160, image width in pixels
IMG_H, 120, image height in lines
H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in pixel ticks
V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pix_ce  in  1  pixel clock enable; everything advances only when high
addr_out  out  AW  read address to buffer
regread  out  1  read enable to buffer
data_in  in  DW  buffer read data (registered in buffer, 1 clk after regread)
vga_hsync  out  1  horizontal sync, active-low, registered
vga_vsync  out  1  vertical sync, active-low, registered
vga_data  out  DW  pixel to DAC, registered
display_en  out  1  high while output pixel is in 640x480 visible area, registered
frame_start  out  1  one-tick pulse coincident with pixel (0,0) on vga_data

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: h_cnt=0, v_cnt=0, addr_cnt=0, all pipeline registers cleared.
  - Output reset values: vga_hsync=1, vga_vsync=1, vga_data=0, display_en=0, frame_start=0.
  - regread is forced 0 while rst=1.
- Counters (advance only on clk edges with pix_ce=1):
  - h_cnt counts 0..H_TOT-1, where H_TOT=800, then wraps to 0.
  - v_cnt increments when h_cnt wraps; it counts 0..V_TOT-1, where V_TOT=525, then wraps to 0.
- Stage 0 (combinational from counters):
  - in_img = (h_cnt < IMG_W) && (v_cnt < IMG_H).
  - vis = (h_cnt < H_VIS) && (v_cnt < V_VIS).
  - hs = !(H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC).
  - vs = !(V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC).
  - regread = in_img & pix_ce & !rst.
  - addr_out = addr_cnt.
- Address counter (no multiplier):
  - On a pix_ce edge with in_img=1, addr_cnt increments.
  - When the counters wrap to (0,0), addr_cnt reloads 0; this overrides the increment.
  - Invariant: whenever in_img=1, addr_out = v_cnt*IMG_W + h_cnt.
  - Last image pixel (159,119) has address 19199.
  - addr_cnt holds its value outside the image region.
- Stage 1 (registered on pix_ce): hs, vs, vis, in_img, first=(h_cnt==0 && v_cnt==0).
- Stage 2 (registered on pix_ce):
  - vga_hsync, vga_vsync, display_en and frame_start copy their stage-1 values.
  - vga_data = in_img_s1 ? data_in : 0.
- Latency:
  - Counter value to pins: exactly 2 pix_ce ticks.
  - Buffer data captured at the stage-1 edge is sampled at the stage-2 edge; this matches the buffer's 1-clk registered read.
- pix_ce=0:
  - All registers hold and regread=0.
  - The buffer output holds because it is not re-read, so alignment survives any ce pattern.
- Boundaries:
  - h wrap at 799: v increments the same edge.
  - v wrap at 524: addr_cnt returns to 0 and the next frame reads address 0 first.
  - Image region never extends past the visible area (IMG_W<=H_VIS, IMG_H<=V_VIS).
- Reset mid-frame: outputs go to their reset values immediately (async). After release, the timing restarts at (0,0) with address 0 on the first pix_ce tick.
- Buffer write port is not driven by this block; concurrent writes may tear, which is acceptable.

Test Plan:
1. Reset: assert rst with pix_ce=1, release.
   -> vga_hsync=vga_vsync=1, vga_data=0 and regread=0 during reset.
   -> First ticks read addr_out 0,1,2,...
   -> frame_start=1 exactly 2 ticks after release, with vga_data = mem[0].
2. Line 0 scan, memory preloaded with mem[a]=a[7:0].
   -> regread high for h=0..159 with addr 0..159, low for h=160..799.
   -> vga_data follows the addr pattern 2 ticks later, then 0.
   -> Line 1 starts at addr 160.
3. Frame boundary.
   -> Address 19199 read at (159,119); no regread for v=120..524.
   -> Next frame first read is addr 0.
   -> vga_vsync low for exactly 2 lines (v=490,491, delayed 2 ticks).
4. hsync timing.
   -> vga_hsync low for exactly 96 ticks, starting 2 ticks after h_cnt=656.
   -> display_en high for 640 ticks per visible line, 480 lines per frame.
5. pix_ce toggling 1,0,1,0 (25 MHz from 50 MHz).
   -> Counters and addr advance every other clk; regread pulses only on ce cycles.
   -> Pixel/sync alignment is identical to test 2.
6. Reset asserted at (300,50) for 3 clks.
   -> Outputs reset asynchronously; after release, addr sequence restarts at 0 and no stale pixel appears on vga_data.
